// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared definitions for the instruction-fetch unit.
//   br_mode_e        : branch compare mode encodings
//   RA_REG           : return-address register number ($31)
//   DEFAULT_RESET_PC : default PC loaded by reset
package ifetch_pkg;

  typedef enum logic [2:0] {
    BR_NONE = 3'd0,
    BR_BEQ  = 3'd1,
    BR_BNE  = 3'd2,
    BR_BGEZ = 3'd3,
    BR_BGTZ = 3'd4,
    BR_BLEZ = 3'd5,
    BR_BLTZ = 3'd6,
    BR_RSVD = 3'd7
  } br_mode_e;

  localparam logic [4:0]  RA_REG           = 5'd31;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifetch_ras.sv
// ifetch_ras: circular return-address stack, updated on the falling edge.
//   clock, reset : clock (falling edge active), async active-high reset
//   push         : push push_data; when full the oldest entry is overwritten
//   pop          : pop the top entry; ignored when empty
//   top          : current top-of-stack value
//   empty        : no valid entries
module ifetch_ras
  #(parameter int W     = 32,
    parameter int DEPTH = 4)
  (input  logic         clock,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top,
   output logic         empty);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] ptr;     // index of the current top entry
  logic [PW-1:0] ptr_inc;
  logic [CW-1:0] cnt;

  // DEPTH is a power of two, so the pointer wraps naturally.
  assign ptr_inc = ptr + 1'b1;
  assign top     = mem[ptr];
  assign empty   = (cnt == '0);

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      ptr <= '0;
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      ptr          <= ptr_inc;
      mem[ptr_inc] <= push_data;
      if (cnt != CW'(DEPTH)) cnt <= cnt + 1'b1;
    end else if (pop && !empty) begin
      ptr <= ptr - 1'b1;
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC register and next-PC selection for the single-cycle MIPS.
// State updates on the falling edge of clock; reset is async active-high.
// Optional feature macro: IFETCH_RAS_EN (return-address stack + ras_mismatch_o).
// Ports:
//   clock, reset       : clock / async reset
//   stall_i            : hold PC, link register and counter
//   instruction_i/_o   : ROM instruction in, passed straight through
//   rom_adr_o          : word address to ROM (PC[ROM_AW+1:2])
//   branch_base_addr   : PC+4 to the ALU
//   addr_result        : ALU branch target
//   read_data_1        : rs value (jr target, sign compares)
//   br_mode_i, zero_i  : branch compare mode and ALU zero
//   jmp_i, jal_i, jr_i : jump controls
//   link_addr          : PC+4 of the last jal
//   misalign_o         : sticky, a redirect target had bits [1:0] != 0
//   instret_o          : retired (non-stalled) cycle count
//   ras_mismatch_o     : sticky RAS prediction mismatch (IFETCH_RAS_EN only)
module ifetch_unit
  import ifetch_pkg::*;
  #(parameter int                ADDR_W    = 32,
    parameter int                ROM_AW    = 14,
    parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter int                RAS_DEPTH = 4)
  (input  logic              clock,
   input  logic              reset,
   input  logic              stall_i,
   input  logic [31:0]       instruction_i,
   output logic [31:0]       instruction_o,
   output logic [ROM_AW-1:0] rom_adr_o,
   output logic [ADDR_W-1:0] branch_base_addr,
   input  logic [ADDR_W-1:0] addr_result,
   input  logic [31:0]       read_data_1,
   input  logic [2:0]        br_mode_i,
   input  logic              zero_i,
   input  logic              jmp_i,
   input  logic              jal_i,
   input  logic              jr_i,
   output logic [ADDR_W-1:0] link_addr,
   output logic              misalign_o,
   output logic [31:0]       instret_o
`ifdef IFETCH_RAS_EN
   ,output logic             ras_mismatch_o
`endif
  );

  if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_chk
    $error("RAS_DEPTH must be a power of two, at least 2");
  end

  logic [ADDR_W-1:0] pc, pc_plus4, pc_next, jtgt, tgt_raw, rd1_a;
  logic              take, redirect, mis_hit, rd1_zero, rd1_neg;

  assign instruction_o    = instruction_i;
  assign rom_adr_o        = pc[ROM_AW+1:2];
  assign pc_plus4         = pc + ADDR_W'(4);
  assign branch_base_addr = pc_plus4;
  assign rd1_a            = ADDR_W'(read_data_1);
  assign rd1_zero         = (read_data_1 == 32'h0);
  assign rd1_neg          = read_data_1[31];

  always_comb begin
    take = 1'b0;
    case (br_mode_i)
      BR_BEQ:  take = zero_i;
      BR_BNE:  take = !zero_i;
      BR_BGEZ: take = !rd1_neg;
      BR_BGTZ: take = !rd1_neg && !rd1_zero;
      BR_BLEZ: take = rd1_neg || rd1_zero;
      BR_BLTZ: take = rd1_neg;
      default: take = 1'b0;
    endcase

    // Region jump keeps the PC's top four bits.
    jtgt       = pc;
    jtgt[27:0] = {instruction_i[25:0], 2'b00};

    redirect = 1'b1;
    if (jmp_i || jal_i) tgt_raw = jtgt;
    else if (jr_i)      tgt_raw = rd1_a;
    else if (take)      tgt_raw = addr_result;
    else begin
      tgt_raw  = pc_plus4;
      redirect = 1'b0;
    end

    pc_next = {tgt_raw[ADDR_W-1:2], 2'b00};
    mis_hit = redirect && (tgt_raw[1:0] != 2'b00);
  end

  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      pc         <= RESET_PC;
      link_addr  <= '0;
      misalign_o <= 1'b0;
      instret_o  <= '0;
    end else if (!stall_i) begin
      pc        <= pc_next;
      instret_o <= instret_o + 32'd1;
      if (jal_i)   link_addr  <= pc_plus4;
      if (mis_hit) misalign_o <= 1'b1;
    end
  end

`ifdef IFETCH_RAS_EN
  logic              ras_push, ras_pop, ras_empty;
  logic [ADDR_W-1:0] ras_top;

  // jal pushes; only a jr through $31 that actually wins the priority pops.
  assign ras_push = jal_i && !stall_i;
  assign ras_pop  = jr_i && !jmp_i && !jal_i && !stall_i &&
                    (instruction_i[25:21] == RA_REG);

  ifetch_ras #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clock    (clock),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_plus4),
    .top      (ras_top),
    .empty    (ras_empty)
  );

  always_ff @(negedge clock or posedge reset) begin
    if (reset)                                          ras_mismatch_o <= 1'b0;
    else if (ras_pop && !ras_empty && ras_top != rd1_a) ras_mismatch_o <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: table-driven check of ifetch_unit plus hand sequences for
// async reset and (when IFETCH_RAS_EN is defined) the return-address stack.
module tb_ifetch_unit;

  logic        clock = 1'b0;
  logic        reset, stall_i, zero_i, jmp_i, jal_i, jr_i;
  logic [31:0] instruction_i, instruction_o, addr_result, read_data_1;
  logic [31:0] branch_base_addr, link_addr, instret_o;
  logic [13:0] rom_adr_o;
  logic [2:0]  br_mode_i;
  logic        misalign_o;
`ifdef IFETCH_RAS_EN
  logic        ras_mismatch_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  ifetch_unit #(.ADDR_W(32), .ROM_AW(14), .RESET_PC(32'h0), .RAS_DEPTH(2)) dut (
    .clock(clock), .reset(reset), .stall_i(stall_i),
    .instruction_i(instruction_i), .instruction_o(instruction_o),
    .rom_adr_o(rom_adr_o), .branch_base_addr(branch_base_addr),
    .addr_result(addr_result), .read_data_1(read_data_1),
    .br_mode_i(br_mode_i), .zero_i(zero_i),
    .jmp_i(jmp_i), .jal_i(jal_i), .jr_i(jr_i),
    .link_addr(link_addr), .misalign_o(misalign_o), .instret_o(instret_o)
`ifdef IFETCH_RAS_EN
    , .ras_mismatch_o(ras_mismatch_o)
`endif
  );

  typedef struct {
    logic        stall;
    logic [2:0]  mode;
    logic        zero, jmp, jal, jr;
    logic [31:0] instr, ar, rd1;
    logic [31:0] pc, link;
    logic        mis;
    logic [31:0] ir;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic s, logic [2:0] m, logic z, logic j, logic jl,
                              logic r, logic [31:0] ins, logic [31:0] ar,
                              logic [31:0] rd1, logic [31:0] pc, logic [31:0] lk,
                              logic mis, logic [31:0] ir);
    vec_t v;
    v.stall = s; v.mode = m; v.zero = z; v.jmp = j; v.jal = jl; v.jr = r;
    v.instr = ins; v.ar = ar; v.rd1 = rd1; v.pc = pc; v.link = lk;
    v.mis = mis; v.ir = ir;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    stall_i = v.stall; br_mode_i = v.mode; zero_i = v.zero;
    jmp_i = v.jmp; jal_i = v.jal; jr_i = v.jr;
    instruction_i = v.instr; addr_result = v.ar; read_data_1 = v.rd1;
  endtask

  task automatic check_state(string tag, logic [31:0] pc, logic [31:0] lk,
                             logic mis, logic [31:0] ir);
    logic [31:0] bba;
    bba = pc + 32'd4;
    chk({tag, " rom_adr"}, {18'h0, rom_adr_o}, {18'h0, pc[15:2]});
    chk({tag, " bba"}, branch_base_addr, bba);
    chk({tag, " link"}, link_addr, lk);
    chk({tag, " misalign"}, {31'h0, misalign_o}, {31'h0, mis});
    chk({tag, " instret"}, instret_o, ir);
  endtask

  task automatic step(vec_t v, string tag);
    drive(v);
    @(negedge clock); #1;
    check_state(tag, v.pc, v.link, v.mis, v.ir);
    chk({tag, " instr_pass"}, instruction_o, v.instr);
  endtask

  task automatic idle();
    drive(mk(0, 3'd0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0, 0));
  endtask

  initial begin
    reset = 1'b1;
    idle();
    @(negedge clock); @(negedge clock); #1;
    check_state("reset", 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0;

    //            st mode   z j jl r  instr         ar            rd1           pc            link     mis ir
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h4,        32'h0,  0, 1));
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h8,        32'h0,  0, 2));
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'hC,        32'h0,  0, 3));
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h10,       32'h0,  0, 4));
    vecs.push_back(mk(0, 3'd4, 0, 0, 0, 0, 32'h0,        32'h100,      32'h0,        32'h14,       32'h0,  0, 5));  // bgtz 0
    vecs.push_back(mk(0, 3'd4, 0, 0, 0, 0, 32'h0,        32'h100,      32'h5,        32'h100,      32'h0,  0, 6));  // bgtz 5
    vecs.push_back(mk(0, 3'd6, 0, 0, 0, 0, 32'h0,        32'h200,      32'h8000_0000,32'h200,      32'h0,  0, 7));  // bltz neg
    vecs.push_back(mk(0, 3'd2, 1, 0, 0, 0, 32'h0,        32'h300,      32'h0,        32'h204,      32'h0,  0, 8));  // bne z=1
    vecs.push_back(mk(0, 3'd1, 1, 0, 0, 0, 32'h0,        32'h30,       32'h0,        32'h30,       32'h0,  0, 9));  // beq z=1
    vecs.push_back(mk(0, 3'd5, 0, 0, 0, 0, 32'h0,        32'h3C,       32'hFFFF_FFFF,32'h3C,       32'h0,  0, 10)); // blez neg
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h40,       32'h0,  0, 11));
    vecs.push_back(mk(0, 3'd0, 0, 0, 1, 0, 32'h0C00_0100,32'h0,        32'h0,        32'h400,      32'h44, 0, 12)); // jal
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h44,       32'h44,       32'h44, 0, 13)); // jr
    vecs.push_back(mk(1, 3'd0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h999,      32'h44,       32'h44, 0, 13)); // stall x3
    vecs.push_back(mk(1, 3'd0, 0, 0, 1, 0, 32'h0C00_0200,32'h0,        32'h0,        32'h44,       32'h44, 0, 13));
    vecs.push_back(mk(1, 3'd1, 1, 0, 0, 0, 32'h0,        32'h500,      32'h0,        32'h44,       32'h44, 0, 13));
    vecs.push_back(mk(0, 3'd1, 1, 0, 0, 1, 32'h0,        32'h500,      32'h80,       32'h80,       32'h44, 0, 14)); // jr beats beq
    vecs.push_back(mk(0, 3'd0, 0, 0, 1, 1, 32'h0C00_0030,32'h0,        32'h500,      32'hC0,       32'h84, 0, 15)); // jal beats jr
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 1, 32'h0,        32'h0,        32'h46,       32'h44,       32'h84, 1, 16)); // misaligned jr
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h48,       32'h84, 1, 17)); // sticky
    vecs.push_back(mk(0, 3'd3, 0, 0, 0, 0, 32'h0,        32'h1002,     32'h0,        32'h1000,     32'h84, 1, 18)); // bgez 0
    vecs.push_back(mk(0, 3'd6, 0, 0, 0, 0, 32'h0,        32'h2000,     32'h1,        32'h1004,     32'h84, 1, 19)); // bltz pos
    vecs.push_back(mk(0, 3'd7, 1, 0, 0, 0, 32'h0,        32'h2000,     32'h0,        32'h1008,     32'h84, 1, 20)); // reserved
    vecs.push_back(mk(0, 3'd3, 0, 0, 0, 0, 32'h0,        32'h2000,     32'h8000_0000,32'h100C,     32'h84, 1, 21)); // bgez neg
    vecs.push_back(mk(0, 3'd0, 0, 1, 0, 0, 32'h0000_0010,32'h0,        32'h0,        32'h40,       32'h84, 1, 22)); // j
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 1, 32'h0,        32'h0,        32'hFFFF_FFFC,32'hFFFF_FFFC,32'h84, 1, 23)); // top
    vecs.push_back(mk(0, 3'd0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h0,        32'h0,        32'h84, 1, 24)); // wrap

    foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

    // Async reset between edges, with stall held: reset wins immediately.
    idle();
    stall_i = 1'b1;
    @(posedge clock); #2;
    reset = 1'b1;
    #1;
    check_state("async_rst", 32'h0, 32'h0, 1'b0, 32'd0);
    @(negedge clock); #1;
    check_state("rst_stall", 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0;
    stall_i = 1'b0;
    @(negedge clock); #1;
    check_state("post_rst", 32'h4, 32'h0, 1'b0, 32'd1);

`ifdef IFETCH_RAS_EN
    reset = 1'b1; #1; reset = 1'b0;
    step(mk(0, 3'd0, 0, 0, 1, 0, 32'h0C00_0010, 0, 0,         32'h40,  32'h4,   0, 1), "ras_jal1");
    step(mk(0, 3'd0, 0, 0, 1, 0, 32'h0C00_0020, 0, 0,         32'h80,  32'h44,  0, 2), "ras_jal2");
    step(mk(0, 3'd0, 0, 0, 1, 0, 32'h0C00_0030, 0, 0,         32'hC0,  32'h84,  0, 3), "ras_jal3");
    step(mk(0, 3'd0, 0, 0, 0, 1, 32'h03E0_0008, 0, 32'h84,    32'h84,  32'h84,  0, 4), "ras_ret1");
    chk("ras_mm_ret1", {31'h0, ras_mismatch_o}, 32'h0);
    step(mk(0, 3'd0, 0, 0, 0, 1, 32'h03E0_0008, 0, 32'h44,    32'h44,  32'h84,  0, 5), "ras_ret2");
    chk("ras_mm_ret2", {31'h0, ras_mismatch_o}, 32'h0);
    step(mk(0, 3'd0, 0, 0, 0, 1, 32'h03E0_0008, 0, 32'h600,   32'h600, 32'h84,  0, 6), "ras_empty");
    chk("ras_mm_empty", {31'h0, ras_mismatch_o}, 32'h0);
    step(mk(0, 3'd0, 0, 0, 1, 0, 32'h0C00_0040, 0, 0,         32'h100, 32'h604, 0, 7), "ras_jal4");
    step(mk(0, 3'd0, 0, 0, 0, 1, 32'h03E0_0008, 0, 32'h700,   32'h700, 32'h604, 0, 8), "ras_bad");
    chk("ras_mm_bad", {31'h0, ras_mismatch_o}, 32'h1);
    #2 reset = 1'b1; #1;
    chk("ras_mm_rst", {31'h0, ras_mismatch_o}, 32'h0);
    check_state("ras_rst", 32'h0, 32'h0, 1'b0, 32'd0);
    reset = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
